// File: rtl/inst_fetch.sv
// Instruction-fetch responder: turns PC/ce requests into req/ack memory reads and
// returns one word per fetch with a valid strobe. Optional IFETCH_LASTHIT_EN adds a one-entry last-hit buffer.
module inst_fetch #(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc_i,
    input  logic              ce_i,
    input  logic              flush_i,
    output logic              bbl_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [31:0] NOP = 32'h0000_0000;

    state_t            state_reg;
    logic [7:0]        cnt_reg;
    logic [31:0]       inst_reg;
    logic              valid_reg;
    logic              err_reg;
    logic              req_reg;
    logic              drop_reg;
    logic [ADDR_W-1:0] addr_reg;

    logic [ADDR_W-1:0] pc_word;
    logic              pc_misaligned;
    logic              hit;

    assign pc_word       = pc_i[ADDR_W+1:2];
    assign pc_misaligned = (pc_i[1:0] != 2'b00);

`ifdef IFETCH_LASTHIT_EN
    logic              lh_valid_reg;
    logic [ADDR_W-1:0] lh_tag_reg;
    logic [31:0]       lh_data_reg;

    assign hit = lh_valid_reg && (lh_tag_reg == pc_word);
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            inst_reg  <= NOP;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            req_reg   <= 1'b0;
            drop_reg  <= 1'b0;
            addr_reg  <= '0;
`ifdef IFETCH_LASTHIT_EN
            lh_valid_reg <= 1'b0;
            lh_tag_reg   <= '0;
            lh_data_reg  <= NOP;
`endif
        end else begin
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ce_i) begin
                        if (pc_misaligned) begin
                            inst_reg  <= NOP;
                            err_reg   <= 1'b1;
                            valid_reg <= !flush_i;
                            state_reg <= DONE;
                        end else if (hit) begin
`ifdef IFETCH_LASTHIT_EN
                            inst_reg  <= lh_data_reg;
`endif
                            valid_reg <= !flush_i;
                            state_reg <= DONE;
                        end else begin
                            addr_reg  <= pc_word;
                            cnt_reg   <= 8'd0;
                            req_reg   <= 1'b1;
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (flush_i) begin
                        drop_reg <= 1'b1;
                    end
                    // An ack in the last allowed cycle still wins over the timeout.
                    if (mem_ack_i) begin
                        inst_reg  <= mem_rdata_i;
                        valid_reg <= !(drop_reg || flush_i);
                        req_reg   <= 1'b0;
                        state_reg <= DONE;
`ifdef IFETCH_LASTHIT_EN
                        lh_valid_reg <= 1'b1;
                        lh_tag_reg   <= addr_reg;
                        lh_data_reg  <= mem_rdata_i;
`endif
                    end else if (cnt_reg == TIMEOUT_C) begin
                        inst_reg  <= NOP;
                        err_reg   <= 1'b1;
                        valid_reg <= !(drop_reg || flush_i);
                        req_reg   <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    drop_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    req_reg   <= 1'b0;
                    drop_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The PC is released only during DONE, so it advances as the word is delivered.
    assign bbl_o        = ce_i && (state_reg != DONE);
    assign inst_o       = inst_reg;
    assign inst_valid_o = valid_reg;
    assign err_o        = err_reg;
    assign mem_req_o    = req_reg;
    assign mem_addr_o   = addr_reg;

endmodule
